// File: rtl/ddr_pkg.sv
// ddr_pkg: shared constants and FSM state type for the DDR packet reader
package ddr_pkg;
    localparam int DDR_LINE_W         = 256;
    localparam int DDR_ADDR_W         = 25;
    localparam int WORDS_PER_LINE     = 8;
    localparam int HDR_LEN_WORD       = 1;
    localparam int PAYLOAD_FIRST_WORD = 2;

    typedef enum logic [3:0] {
        IDLE,
        HDR_REQ,
        HDR_WAIT,
        CHECK,
        STREAM,
        RD_REQ,
        RD_WAIT,
        DONE,
        ERR
    } rd_state_e;
endpackage

// File: rtl/ddr_line_unpack.sv
// ddr_line_unpack: 8x32 line buffer with a word index that selects the presented word
module ddr_line_unpack
    import ddr_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  set_idx,
    input  logic [2:0]            idx_val,
    input  logic                  advance,
    input  logic [DDR_LINE_W-1:0] line,
    output logic [31:0]           word,
    output logic [15:0]           len,
    output logic                  last
);
    logic [31:0] lane_q [WORDS_PER_LINE];
    logic [2:0]  idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '{default: '0};
            idx    <= '0;
        end else begin
            if (load)
                for (int k = 0; k < WORDS_PER_LINE; k++)
                    lane_q[k] <= line[32*k +: 32];
            if (set_idx)
                idx <= idx_val;
            else if (advance)
                idx <= idx + 3'd1;
        end
    end

    assign word = lane_q[idx];
    assign len  = lane_q[HDR_LEN_WORD][15:0];
    assign last = idx == 3'(WORDS_PER_LINE - 1);
endmodule

// File: rtl/ddr_pkt_reader_256.sv
// ddr_pkt_reader_256: reads a length-prefixed frame from DDR one 256-bit line at a time
// and streams it as 32-bit words with sop/eop/empty framing and valid/ready backpressure.
module ddr_pkt_reader_256
    import ddr_pkg::*;
#(
    parameter logic [DDR_ADDR_W-1:0] BASE_LINE = 25'd0,
    parameter logic [15:0]           MAX_BYTES = 16'd2048,
    parameter logic [15:0]           TIMEOUT   = 16'd1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  rd_rq,
    output logic [DDR_ADDR_W-1:0] rd_adr,
    input  logic                  rd_valid,
    input  logic [DDR_LINE_W-1:0] rd_data,
    output logic [31:0]           tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic [1:0]            tx_empty
);
    rd_state_e             state, state_d;
    logic [DDR_ADDR_W-1:0] line_q, line_d;
    logic [16:0]           left_q, left_d;
    logic [1:0]            empty_q, empty_d;
    logic                  sop_q, sop_d;
    logic                  error_q, error_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  load, set_idx, advance, last;
    logic [2:0]            idx_val;
    logic [31:0]           word;
    logic [15:0]           len;
    logic                  wait_st, fire, timed_out;

    ddr_line_unpack u_unpack (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .set_idx (set_idx),
        .idx_val (idx_val),
        .advance (advance),
        .line    (rd_data),
        .word    (word),
        .len     (len),
        .last    (last)
    );

    assign wait_st   = state == HDR_WAIT || state == RD_WAIT;
    assign fire      = tx_valid && tx_ready;
    // cnt_q counts cycles since the rd_rq strobe, so ERR lands exactly TIMEOUT cycles after it
    assign timed_out = cnt_q >= TIMEOUT - 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            line_q  <= '0;
            left_q  <= '0;
            empty_q <= '0;
            sop_q   <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_d;
            line_q  <= line_d;
            left_q  <= left_d;
            empty_q <= empty_d;
            sop_q   <= sop_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        line_d  = line_q;
        left_d  = left_q;
        empty_d = empty_q;
        sop_d   = sop_q;
        error_d = error_q;
        cnt_d   = wait_st ? cnt_q + 16'd1 : 16'(rd_rq);
        load    = 1'b0;
        set_idx = 1'b0;
        idx_val = '0;
        advance = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_d = HDR_REQ;
                error_d = 1'b0;
            end
            HDR_REQ: state_d = HDR_WAIT;
            RD_REQ:  state_d = RD_WAIT;
            HDR_WAIT, RD_WAIT: if (rd_valid) begin
                load    = 1'b1;
                set_idx = state == RD_WAIT;
                state_d = state == RD_WAIT ? STREAM : CHECK;
            end else if (timed_out) begin
                state_d = ERR;
            end
            CHECK: if (len == 16'd0 || len > MAX_BYTES) begin
                state_d = ERR;
            end else begin
                state_d = STREAM;
                set_idx = 1'b1;
                idx_val = 3'(PAYLOAD_FIRST_WORD);
                line_d  = BASE_LINE;
                left_d  = (17'(len) + 17'd3) >> 2;
                empty_d = 2'd0 - len[1:0];
                sop_d   = 1'b1;
            end
            STREAM: if (fire) begin
                advance = 1'b1;
                sop_d   = 1'b0;
                left_d  = left_q - 17'd1;
                if (left_q == 17'd1) begin
                    state_d = DONE;
                end else if (last) begin
                    state_d = RD_REQ;
                    line_d  = line_q + DDR_ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == ERR)
            error_d = 1'b1;
    end

    assign busy     = !(state inside {IDLE, DONE, ERR});
    assign done     = state == DONE;
    assign error    = error_q;
    assign rd_rq    = state == HDR_REQ || state == RD_REQ;
    assign rd_adr   = state == HDR_REQ ? BASE_LINE : state == RD_REQ ? line_q : '0;
    assign tx_valid = state == STREAM;
    assign tx_data  = tx_valid ? word : '0;
    assign tx_sop   = tx_valid && sop_q;
    assign tx_eop   = tx_valid && left_q == 17'd1;
    assign tx_empty = tx_eop ? empty_q : '0;
endmodule

// File: tb/tb_ddr_pkt_reader_256.sv
// tb_ddr_pkt_reader_256: directed frames with random payloads against a simple frame model
module tb_ddr_pkt_reader_256;
    logic         clk = 1'b0;
    logic         reset, start, rd_valid, tx_ready;
    logic [255:0] rd_data;
    logic         busy, done, error, rd_rq, tx_valid, tx_sop, tx_eop;
    logic [24:0]  rd_adr;
    logic [31:0]  tx_data;
    logic [1:0]   tx_empty;

    int total = 0, bad = 0, cyc = 0;
    int lat = 0;
    bit drop = 1'b0, rnd_ready = 1'b0;

    logic [31:0] mem [0:127];
    logic [31:0] pay [0:125];
    logic [24:0] rd_log [$];
    logic [31:0] cap_data [$];
    bit          cap_sop [$], cap_eop [$];
    logic [1:0]  cap_empty [$];
    int valid_seen = 0, stall_bad = 0, done_seen = 0;

    ddr_pkt_reader_256 #(.TIMEOUT(16'd16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .rd_rq    (rd_rq),
        .rd_adr   (rd_adr),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sop   (tx_sop),
        .tx_eop   (tx_eop),
        .tx_empty (tx_empty)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // DDR responder: one line per request, lat extra cycles after the minimum
    initial begin
        logic [24:0] a;
        rd_valid = 1'b0;
        rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rd_rq) begin
                a = rd_adr;
                rd_log.push_back(a);
                if (!drop) begin
                    repeat (lat + 1) @(posedge clk);
                    #1;
                    for (int k = 0; k < 8; k++)
                        rd_data[32*k +: 32] = (int'(a) * 8 + k < 128) ? mem[int'(a) * 8 + k] : 32'h0;
                    rd_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    rd_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // sink monitor: records accepted words and checks stability under backpressure
    initial begin
        logic        pv, pr, prst, ps, pe;
        logic [31:0] pd;
        logic [1:0]  pm;
        pv = 0; pr = 0; prst = 1; ps = 0; pe = 0; pd = 0; pm = 0;
        forever begin
            @(negedge clk);
            if (pv && !pr && !prst && {tx_valid, tx_data, tx_sop, tx_eop, tx_empty} !== {pv, pd, ps, pe, pm})
                stall_bad++;
            if (tx_valid) valid_seen++;
            if (done) done_seen++;
            if (tx_valid && tx_ready && !reset) begin
                cap_data.push_back(tx_data);
                cap_sop.push_back(tx_sop);
                cap_eop.push_back(tx_eop);
                cap_empty.push_back(tx_empty);
            end
            pv = tx_valid; pr = tx_ready; prst = reset; pd = tx_data; ps = tx_sop; pe = tx_eop; pm = tx_empty;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        rd_log.delete();
        cap_data.delete();
        cap_sop.delete();
        cap_eop.delete();
        cap_empty.delete();
        valid_seen = 0;
        stall_bad  = 0;
        done_seen  = 0;
    endtask

    task automatic setup_frame(input int len);
        foreach (mem[i]) mem[i] = $urandom;
        foreach (pay[i]) pay[i] = $urandom;
        mem[0] = $urandom;
        mem[1] = {16'($urandom), 16'(len)};
    endtask

    task automatic load_payload;
        foreach (pay[i]) mem[2 + i] = pay[i];
    endtask

    task automatic start_frame;
        clear_logs();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, output bit got_done, output bit got_err);
        got_done = 0;
        got_err  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            got_done = done;
            got_err  = error;
            if (done || error) break;
        end
        chk({tag, " finished"}, 64'(got_done | got_err), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int len);
        int n, reads;
        n     = (len + 3) / 4;
        reads = 1 + (n > 6 ? (n - 6 + 7) / 8 : 0);
        chk({tag, " words"}, 64'(cap_data.size()), 64'(n));
        for (int i = 0; i < n && i < cap_data.size(); i++) begin
            chk($sformatf("%s data%0d", tag, i), 64'(cap_data[i]), 64'(pay[i]));
            chk($sformatf("%s sop%0d", tag, i), 64'(cap_sop[i]), 64'(i == 0));
            chk($sformatf("%s eop%0d", tag, i), 64'(cap_eop[i]), 64'(i == n - 1));
            chk($sformatf("%s empty%0d", tag, i), 64'(cap_empty[i]), 64'(i == n - 1 ? (4 - len % 4) % 4 : 0));
        end
        chk({tag, " done pulses"}, 64'(done_seen), 64'd1);
        chk({tag, " stall changes"}, 64'(stall_bad), 64'd0);
        chk({tag, " reads"}, 64'(rd_log.size()), 64'(reads));
        for (int j = 0; j < rd_log.size(); j++)
            chk($sformatf("%s rd_adr%0d", tag, j), 64'(rd_log[j]), 64'(j));
    endtask

    initial begin
        bit          d, e;
        int          rq_cyc, err_cyc;
        logic [31:0] first;
        reset = 1'b1; start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset ctrl", {busy, done, error, rd_rq, tx_valid, tx_sop, tx_eop}, 64'd0);
        chk("reset adr", 64'(rd_adr), 64'd0);
        chk("reset tx", {tx_data, tx_empty}, 64'd0);

        setup_frame(64); load_payload();
        start_frame();
        wait_end("L64", d, e);
        chk("L64 done", 64'(d), 64'd1);
        chk("L64 busy at done", 64'(busy), 64'd0);
        chk("L64 no error", 64'(error), 64'd0);
        check_frame("L64", 64);

        setup_frame(61); pay[0] = 32'h2005BF6B; load_payload();
        start_frame();
        wait_end("L61", d, e);
        first = cap_data.size() > 0 ? cap_data[0] : 32'hx;
        chk("L61 first word", 64'(first), 64'h2005BF6B);
        check_frame("L61", 61);

        setup_frame(0); load_payload();
        start_frame();
        wait_end("L0", d, e);
        chk("L0 error", 64'(e), 64'd1);
        chk("L0 busy", 64'(busy), 64'd0);
        chk("L0 no valid", 64'(valid_seen), 64'd0);
        chk("L0 no done", 64'(done_seen), 64'd0);

        setup_frame(4096); load_payload();
        start_frame();
        @(negedge clk);
        chk("restart clears error", {error, busy}, 64'b01);
        wait_end("L4096", d, e);
        chk("L4096 error", 64'(e), 64'd1);
        chk("L4096 busy", 64'(busy), 64'd0);
        chk("L4096 no valid", 64'(valid_seen), 64'd0);

        lat = 5; rnd_ready = 1'b1;
        setup_frame(100); load_payload();
        start_frame();
        wait_end("L100", d, e);
        chk("L100 done", 64'(d), 64'd1);
        check_frame("L100", 100);
        rnd_ready = 1'b0;

        drop = 1'b1;
        setup_frame(64); load_payload();
        start_frame();
        rq_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_rq) begin rq_cyc = cyc; break; end
        end
        wait_end("timeout", d, e);
        err_cyc = cyc;
        chk("timeout error", 64'(e), 64'd1);
        chk("timeout latency", 64'(err_cyc - rq_cyc), 64'd16);
        chk("timeout no done", 64'(done_seen), 64'd0);
        drop = 1'b0;
        repeat (3) tick();

        lat = 3;
        setup_frame(64); load_payload();
        start_frame();
        for (int i = 0; i < 500; i++) begin
            tick();
            if (cap_data.size() >= 10) break;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midreset ctrl", {busy, done, error, rd_rq, tx_valid, tx_sop, tx_eop}, 64'd0);
        chk("midreset adr", 64'(rd_adr), 64'd0);
        chk("midreset tx", {tx_data, tx_empty}, 64'd0);
        tick();
        rd_data  = {8{32'hDEADBEEF}};
        rd_valid = 1'b1;
        tick();
        rd_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stale rd_valid ignored", {busy, rd_rq, tx_valid, done, error}, 64'd0);
        end
        chk("midreset no done", 64'(done_seen), 64'd0);

        setup_frame(64); load_payload();
        start_frame();
        wait_end("fresh", d, e);
        chk("fresh done", 64'(d), 64'd1);
        check_frame("fresh", 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
